// File: rtl/quant_div_engine.sv
// Iterative quantisation divider: restoring division of an activation against a
// binary-weighted unit ladder, one index bit per cycle, with optional rounding.
module quant_div_engine #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_activation,
   input  logic [DATA_W-1:0] i_unit,
   input  logic              i_round,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [IDX_W-1:0]  o_index,
   output logic [DATA_W-1:0] o_left,
   output logic              o_ovf,
   output logic              o_sat,
   output logic              o_busy
);

   localparam int unsigned CNT_W = $clog2(IDX_W);

   typedef enum logic [1:0] {StIdle, StRun, StRound, StDone} state_e;

   state_e            state_q;
   logic [DATA_W-1:0] left_q;
   logic [DATA_W-1:0] step_q;
   logic [DATA_W-1:0] unit_q;
   logic [IDX_W-1:0]  index_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              round_q;
   logic              ovf_q;
   logic              sat_q;

   logic              run_bit;
   logic [DATA_W-1:0] lsb_step;
   logic              round_up;

   always_comb begin
      run_bit  = (left_q != '0) && (left_q >= step_q);
      lsb_step = unit_q >> (IDX_W - 1);
      // In ROUND the step register already holds the half-LSB weight
      round_up = round_q && (step_q != '0) && (left_q >= step_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         left_q  <= '0;
         step_q  <= '0;
         unit_q  <= '0;
         index_q <= '0;
         cnt_q   <= '0;
         round_q <= 1'b0;
         ovf_q   <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (i_valid) begin
                  left_q  <= i_activation;
                  step_q  <= i_unit;
                  unit_q  <= i_unit;
                  index_q <= '0;
                  cnt_q   <= '0;
                  round_q <= i_round;
                  ovf_q   <= 1'b0;
                  sat_q   <= 1'b0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               if (run_bit) begin
                  left_q <= left_q - step_q;
               end
               index_q <= {index_q[IDX_W-2:0], run_bit};
               step_q  <= step_q >> 1;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(IDX_W - 1)) begin
                  state_q <= StRound;
               end
            end
            StRound: begin
               ovf_q <= (lsb_step != '0) && (left_q >= lsb_step);
               if (round_up) begin
                  if (&index_q) begin
                     sat_q <= 1'b1;
                  end else begin
                     index_q <= index_q + IDX_W'(1);
                  end
               end
               state_q <= StDone;
            end
            StDone: begin
               if (i_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_ready = (state_q == StIdle);
   assign o_valid = (state_q == StDone);
   assign o_busy  = (state_q != StIdle);
   assign o_index = index_q;
   assign o_left  = left_q;
   assign o_ovf   = ovf_q;
   assign o_sat   = sat_q;

endmodule

// File: tb/tb_quant_div_engine.sv
// Directed bench for quant_div_engine: vector table plus backpressure, cadence
// and mid-run reset sequences.
module tb_quant_div_engine;

   logic        clk;
   logic        reset_n;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_activation;
   logic [31:0] i_unit;
   logic        i_round;
   logic        o_valid;
   logic        i_ready;
   logic [7:0]  o_index;
   logic [31:0] o_left;
   logic        o_ovf;
   logic        o_sat;
   logic        o_busy;

   int passed = 0;
   int total  = 0;

   quant_div_engine #(.DATA_W(32), .IDX_W(8)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_activation (i_activation),
      .i_unit       (i_unit),
      .i_round      (i_round),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_index      (o_index),
      .o_left       (o_left),
      .o_ovf        (o_ovf),
      .o_sat        (o_sat),
      .o_busy       (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] u;
      logic        rnd;
      logic [7:0]  idx;
      logic [31:0] left;
      logic        ovf;
      logic        sat;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!o_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!o_ready) check("ready_timeout", 64'd0, 64'd1);
   endtask

   // Issue one request and return the number of edges from accept to o_valid.
   task automatic issue(input logic [31:0] a, input logic [31:0] u, input logic r,
                        output int lat);
      @(negedge clk);
      wait_ready();
      i_activation = a;
      i_unit       = u;
      i_round      = r;
      i_valid      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_valid      = 1'b0;
      i_activation = $urandom;
      i_unit       = $urandom;
      i_round      = 1'($urandom);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!o_valid && lat < 50);
   endtask

   task automatic consume();
      i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int bad;
      int rises[$];
      logic prev_v;
      logic [7:0]  hold_idx;
      logic [31:0] hold_left;

      vecs[0] = '{32'd100,  32'd64,  1'b0, 8'hC8, 32'd0,   1'b0, 1'b0};
      vecs[1] = '{32'd5,    32'd256, 1'b0, 8'h02, 32'd1,   1'b0, 1'b0};
      vecs[2] = '{32'd5,    32'd256, 1'b1, 8'h03, 32'd1,   1'b0, 1'b0};
      vecs[3] = '{32'd511,  32'd256, 1'b1, 8'hFF, 32'd1,   1'b0, 1'b1};
      vecs[4] = '{32'd1000, 32'd256, 1'b0, 8'hFF, 32'd490, 1'b1, 1'b0};
      vecs[5] = '{32'd0,    32'd64,  1'b0, 8'h00, 32'd0,   1'b0, 1'b0};
      vecs[6] = '{32'd7,    32'd0,   1'b0, 8'hFF, 32'd7,   1'b0, 1'b0};
      vecs[7] = '{32'd1000, 32'd256, 1'b1, 8'hFF, 32'd490, 1'b1, 1'b1};
      vecs[8] = '{32'd6,    32'd256, 1'b1, 8'h03, 32'd0,   1'b0, 1'b0};

      reset_n      = 1'b0;
      i_valid      = 1'b0;
      i_ready      = 1'b0;
      i_activation = '0;
      i_unit       = '0;
      i_round      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(o_ready), 64'd1);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_busy",  64'(o_busy),  64'd0);
      check("rst_index", 64'(o_index), 64'd0);
      check("rst_left",  64'(o_left),  64'd0);
      check("rst_ovf",   64'(o_ovf),   64'd0);
      check("rst_sat",   64'(o_sat),   64'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         issue(vecs[i].a, vecs[i].u, vecs[i].rnd, lat);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'd9);
         check($sformatf("v%0d_index", i), 64'(o_index), 64'(vecs[i].idx));
         check($sformatf("v%0d_left", i),  64'(o_left),  64'(vecs[i].left));
         check($sformatf("v%0d_ovf", i),   64'(o_ovf),   64'(vecs[i].ovf));
         check($sformatf("v%0d_sat", i),   64'(o_sat),   64'(vecs[i].sat));
         consume();
         check($sformatf("v%0d_post_valid", i), 64'(o_valid), 64'd0);
         check($sformatf("v%0d_post_ready", i), 64'(o_ready), 64'd1);
      end

      // Backpressure: stall 20 cycles in DONE while hammering i_valid.
      issue(32'd100, 32'd64, 1'b0, lat);
      check("bp_latency", 64'(lat), 64'd9);
      hold_idx  = o_index;
      hold_left = o_left;
      check("bp_index", 64'(hold_idx), 64'hC8);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         i_valid      = c[0];
         i_activation = 32'd5 + 32'(c);
         i_unit       = 32'd256;
         @(posedge clk);
         @(negedge clk);
         if (o_index !== hold_idx || o_left !== hold_left || !o_valid || o_ready
             || o_ovf || o_sat)
            bad++;
      end
      i_valid = 1'b0;
      check("bp_stable_cycles_bad", 64'(bad), 64'd0);
      consume();
      check("bp_release_ready", 64'(o_ready), 64'd1);

      // Back-to-back cadence with both handshakes held high.
      i_activation = 32'd5;
      i_unit       = 32'd256;
      i_round      = 1'b0;
      i_valid      = 1'b1;
      i_ready      = 1'b1;
      prev_v       = o_valid;
      bad          = 0;
      for (int c = 0; c < 60 && rises.size() < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (o_valid && !prev_v) begin
            rises.push_back(c);
            if (o_index !== 8'h02 || o_left !== 32'd1) bad++;
         end
         prev_v = o_valid;
      end
      i_valid = 1'b0;
      check("cad_rises", 64'(rises.size()), 64'd3);
      if (rises.size() == 3) begin
         check("cad_gap0", 64'(rises[1] - rises[0]), 64'd11);
         check("cad_gap1", 64'(rises[2] - rises[1]), 64'd11);
      end
      check("cad_results_bad", 64'(bad), 64'd0);
      wait_ready();
      i_ready = 1'b0;

      // Reset during RUN iteration 4.
      @(negedge clk);
      i_activation = 32'd100;
      i_unit       = 32'd64;
      i_valid      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("mrst_busy",  64'(o_busy),  64'd0);
      check("mrst_ready", 64'(o_ready), 64'd1);
      check("mrst_valid", 64'(o_valid), 64'd0);
      check("mrst_index", 64'(o_index), 64'd0);
      check("mrst_left",  64'(o_left),  64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (o_valid || o_busy) bad++;
      end
      check("mrst_no_valid", 64'(bad), 64'd0);
      issue(32'd511, 32'd256, 1'b1, lat);
      check("mrst_after_latency", 64'(lat), 64'd9);
      check("mrst_after_index", 64'(o_index), 64'hFF);
      check("mrst_after_sat", 64'(o_sat), 64'd1);
      consume();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/quant_div_engine.md
# quant_div_engine

Parametrised, iterative quantisation divider: converts an unsigned activation into an IDX_W-bit index by restoring division against a binary-weighted unit ladder (U, U>>1, … U>>(IDX_W-1)), one index bit per cycle. Successor to the single-stage quantiser slice. Adds width/depth parameters, valid/ready handshakes, optional round-to-nearest, and overflow/saturation flags. Sits between the activation datapath and index packing.

## Interface
- DATA_W, 32, width of activation, unit and remainder
- IDX_W, 8, index bits and RUN iterations (≥2)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input request
- o_ready  out  1  engine can accept (high only in IDLE)
- i_activation  in  DATA_W  unsigned activation A
- i_unit  in  DATA_W  MSB step weight U
- i_round  in  1  1 = round to nearest, 0 = truncate; sampled at accept
- o_valid  out  1  result valid, held until consumed
- i_ready  in  1  downstream accepts result
- o_index  out  IDX_W  quantised index
- o_left  out  DATA_W  remainder after RUN (pre-rounding)
- o_ovf  out  1  remainder ≥ LSB step (A beyond ladder range)
- o_sat  out  1  rounding increment suppressed at all-ones index
- o_busy  out  1  state ≠ IDLE

## Operation
- FSM: IDLE → RUN → ROUND → DONE → IDLE.
- IDLE: o_ready=1. On i_valid&&o_ready: left←A, step←U, index←0, cnt←0, round flag←i_round, clear flags, go RUN.
- RUN, each cycle: bit = (left≠0) && (left ≥ step). If bit: left←left−step. index←{index[IDX_W-2:0],bit}; step←step>>1 (zero fill); cnt++. After the IDX_W-th iteration go ROUND.
- Unit=0 behaviour: step 0 gives bit=1 whenever left≠0; left is unchanged.
- ROUND (one cycle; step now = U>>IDX_W = half LSB):
  - o_ovf ← (U>>(IDX_W-1))≠0 && left ≥ U>>(IDX_W-1).
  - If round flag && step≠0 && left ≥ step: if index≠all-ones then index+1, else o_sat←1 and index unchanged.
  - Go DONE.
- DONE: o_valid=1. Outputs are frozen. On i_ready go IDLE.
- o_left always reports the RUN remainder; rounding never modifies it.
- All arithmetic is unsigned DATA_W. The subtraction cannot underflow because it is guarded by the compare.

## Timing
- Reset (async assert, sync release by edge): state IDLE, o_ready=1, o_valid=0, o_busy=0, o_index=0, o_left=0, o_ovf=0, o_sat=0.
- Accept at edge T.
  - RUN bits at edges T+1..T+IDX_W.
  - ROUND at T+IDX_W+1.
  - o_valid high after T+IDX_W+1. Latency is IDX_W+1 cycles (9 at IDX_W=8).
- Result handshake at edge R (o_valid&&i_ready). o_valid falls and o_ready rises after R.
- Throughput: one result per IDX_W+3 cycles when i_valid and i_ready are held high.
- i_valid while busy: ignored (o_ready=0). The inputs are not captured.
- i_ready low in DONE: stall indefinitely with outputs stable.
- i_activation, i_unit and i_round may change freely after the accept edge.
- reset_n asserted mid-RUN/ROUND/DONE: immediate return to reset values. The in-flight result is discarded and o_valid is never raised for it.

## Test plan
- IDX_W=8, A=100, U=64, truncate -> o_index=0xC8, o_left=0, o_ovf=0, o_sat=0; o_valid 9 cycles after accept.
- A=5, U=256: i_round=0 -> o_index=0x02, o_left=1; i_round=1 -> o_index=0x03, o_left=1.
- A=511, U=256, i_round=1 -> o_index=0xFF, o_left=1, o_sat=1, o_ovf=0. A=1000, U=256 -> o_index=0xFF, o_left=490, o_ovf=1.
- A=0, U=64 -> o_index=0x00, o_left=0; A=7, U=0 -> o_index=0xFF, o_left=7.
- Backpressure: hold i_ready=0 for 20 cycles in DONE, pulse i_valid meanwhile. Outputs stay stable, o_ready=0, no new capture. Release i_ready, then back-to-back requests give a cadence of 11 cycles.
- Assert reset_n low at RUN iteration 4 -> all outputs at reset values within the same cycle; o_valid stays 0. A new request after release completes normally.
